// File: rtl/framer_pkg.sv
// Shared types and constants for stream_framer: FSM state encoding,
// default header word and frame counter width.
package framer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PAYLOAD  = 2'd1,
    CHECKSUM = 2'd2
  } state_t;

  localparam logic [15:0] HEADER_WORD = 16'hA5A5;
  localparam int          FRAME_CNT_W = 16;

endpackage

// File: rtl/framer_out_reg.sv
// Single-entry valid/ready output register. free means a new word may be
// loaded this cycle (empty, or the held word is being accepted now).
module framer_out_reg #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_word,
  input  logic         rdy,
  output logic [W-1:0] word,
  output logic         val,
  output logic         free
);

  assign free = !val | rdy;

  // Handshake: a word transfers on val & rdy; word is held stable while val & !rdy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
      val  <= 1'b0;
    end else if (load) begin
      word <= load_word;
      val  <= 1'b1;
    end else if (rdy) begin
      val  <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_framer.sv
// Pops payload words from a FIFO and emits header + FrameLen payload words
// (+ checksum word when STREAM_FRAMER_CHECKSUM_EN is defined) as framed output.
module stream_framer
  import framer_pkg::*;
#(
  parameter int                   DataWidth  = 16,
  parameter int                   FrameLen   = 4,
  parameter logic [DataWidth-1:0] HeaderWord = DataWidth'(HEADER_WORD)
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic [DataWidth-1:0]   din_i,
  input  logic                   din_val_i,
  output logic                   din_rdy_o,
  output logic [DataWidth-1:0]   dout_o,
  output logic                   dout_val_o,
  output logic                   dout_last_o,
  input  logic                   dout_rdy_i,
  output logic                   busy_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o,
  output logic [1:0]             dbg_state
);

  localparam int             CW       = $clog2(FrameLen + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(FrameLen - 1);

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic                 load, ld_last, free, in_hs, out_hs;
  logic [DataWidth-1:0] ld_data;
  logic [DataWidth:0]   out_word;
`ifdef STREAM_FRAMER_CHECKSUM_EN
  logic [DataWidth-1:0] sum, sum_n;
`endif

  assign in_hs     = din_val_i & din_rdy_o;
  assign out_hs    = dout_val_o & dout_rdy_i;
  assign busy_o    = (state != IDLE) | dout_val_o;
  assign dbg_state = state;
  assign {dout_last_o, dout_o} = out_word;

  framer_out_reg #(.W(DataWidth + 1)) u_out (
    .clk       (clk_i),
    .rst       (arst_i),
    .load      (load),
    .load_word ({ld_last, ld_data}),
    .rdy       (dout_rdy_i),
    .word      (out_word),
    .val       (dout_val_o),
    .free      (free)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      frame_cnt_o <= '0;
`ifdef STREAM_FRAMER_CHECKSUM_EN
      sum         <= '0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
`ifdef STREAM_FRAMER_CHECKSUM_EN
      sum   <= sum_n;
`endif
      if (out_hs && dout_last_o) frame_cnt_o <= frame_cnt_o + 1'b1;
    end
  end

  // The header is loaded from IDLE without popping din; payload pops only in PAYLOAD.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    load      = 1'b0;
    ld_last   = 1'b0;
    ld_data   = '0;
    din_rdy_o = 1'b0;
`ifdef STREAM_FRAMER_CHECKSUM_EN
    sum_n     = sum;
`endif
    case (state)
      IDLE: begin
        if (din_val_i && free) begin
          load    = 1'b1;
          ld_data = HeaderWord;
          cnt_n   = '0;
`ifdef STREAM_FRAMER_CHECKSUM_EN
          sum_n   = '0;
`endif
          state_n = PAYLOAD;
        end
      end
      PAYLOAD: begin
        din_rdy_o = free;
        if (in_hs) begin
          load    = 1'b1;
          ld_data = din_i;
          cnt_n   = cnt + CW'(1);
`ifdef STREAM_FRAMER_CHECKSUM_EN
          sum_n   = sum + din_i;
          if (cnt == LAST_IDX) state_n = CHECKSUM;
`else
          if (cnt == LAST_IDX) begin
            ld_last = 1'b1;
            state_n = IDLE;
          end
`endif
        end
      end
`ifdef STREAM_FRAMER_CHECKSUM_EN
      CHECKSUM: begin
        if (free) begin
          load    = 1'b1;
          ld_data = sum;
          ld_last = 1'b1;
          state_n = IDLE;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_stream_framer.sv
// Scoreboard bench for stream_framer (FrameLen=4); expectations follow
// STREAM_FRAMER_CHECKSUM_EN when it is defined for the build.
module tb_stream_framer;

  localparam int FRAME_LEN = 4;
`ifdef STREAM_FRAMER_CHECKSUM_EN
  localparam int WPF = FRAME_LEN + 2;
`else
  localparam int WPF = FRAME_LEN + 1;
`endif

  logic        clk = 1'b0;
  logic        arst_i = 1'b1;
  logic [15:0] din_i = '0;
  logic        din_val_i = 1'b0;
  logic        din_rdy_o;
  logic [15:0] dout_o;
  logic        dout_val_o;
  logic        dout_last_o;
  logic        dout_rdy_i = 1'b1;
  logic        busy_o;
  logic [15:0] frame_cnt_o;
  logic [1:0]  dbg_state;

  logic [16:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int hs_total = 0;
  int last_hs_cyc = 0;
  int tp_first = -1;
  bit tp_arm = 1'b0;

  stream_framer #(.DataWidth(16), .FrameLen(FRAME_LEN), .HeaderWord(16'hA5A5)) dut (
    .clk_i       (clk),
    .arst_i      (arst_i),
    .din_i       (din_i),
    .din_val_i   (din_val_i),
    .din_rdy_o   (din_rdy_o),
    .dout_o      (dout_o),
    .dout_val_o  (dout_val_o),
    .dout_last_o (dout_last_o),
    .dout_rdy_i  (dout_rdy_i),
    .busy_o      (busy_o),
    .frame_cnt_o (frame_cnt_o),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // monitor: every accepted output word is popped from the expected queue
  initial forever begin
    @(negedge clk);
    if (!arst_i && dout_val_o && dout_rdy_i) begin
      hs_total++;
      last_hs_cyc = cyc;
      if (tp_arm && tp_first < 0) tp_first = cyc;
      if (exp_q.size() == 0) fail_now($sformatf("unexpected_word %0h", {dout_last_o, dout_o}));
      else check("out_word{last,data}", {15'b0, dout_last_o, dout_o}, {15'b0, exp_q.pop_front()});
    end
  end

  // driver tasks
  task automatic put(input logic [15:0] w, input int gap);
    bit got = 1'b0;
    if (gap > 0) begin
      din_val_i = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    din_i = w;
    din_val_i = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (din_rdy_o) got = 1'b1;
    end
    if (!got) fail_now("put_timeout");
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [15:0] w0, w1, w2, w3, input int gap);
    logic [15:0] w[4];
    logic [15:0] s = '0;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    exp_q.push_back({1'b0, 16'hA5A5});
    for (int i = 0; i < 4; i++) begin
      s = s + w[i];
`ifdef STREAM_FRAMER_CHECKSUM_EN
      exp_q.push_back({1'b0, w[i]});
`else
      exp_q.push_back({(i == 3), w[i]});
`endif
    end
`ifdef STREAM_FRAMER_CHECKSUM_EN
    exp_q.push_back({1'b1, s});
`endif
    for (int i = 0; i < 4; i++) put(w[i], (i > 0) ? gap : 0);
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int t = 0; t < 500 && !done; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy_o) done = 1'b1;
    end
    if (!done) fail_now({name, "_drain_timeout"});
  endtask

  initial begin
    int base;
    logic [16:0] held;
    bit seen;

    #12;
    check("reset_dout", {16'b0, dout_o}, 32'h0);
    check("reset_val", {31'b0, dout_val_o}, 32'h0);
    check("reset_last", {31'b0, dout_last_o}, 32'h0);
    check("reset_din_rdy", {31'b0, din_rdy_o}, 32'h0);
    check("reset_busy", {31'b0, busy_o}, 32'h0);
    check("reset_frame_cnt", {16'b0, frame_cnt_o}, 32'h0);
    check("reset_state", {30'b0, dbg_state}, 32'h0);
    @(posedge clk); #1;
    arst_i = 1'b0;
    @(posedge clk); #1;

    // basic frame: checksum 000A
    send_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004, 0);
    din_val_i = 1'b0;
    drain("basic");
    check("frame_cnt_basic", {16'b0, frame_cnt_o}, 32'd1);

    // checksum wrap: FFFF+2+0+1 -> 0002
    send_frame(16'hFFFF, 16'h0002, 16'h0000, 16'h0001, 0);
    din_val_i = 1'b0;
    drain("wrap");
    check("frame_cnt_wrap", {16'b0, frame_cnt_o}, 32'd2);

    // downstream stall for 3 cycles while payload 0006 is presented
    base = hs_total;
    fork
      begin
        send_frame(16'h0005, 16'h0006, 16'h0007, 16'h0008, 0);
        din_val_i = 1'b0;
      end
      begin
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
          @(posedge clk); #1;
          if (dout_val_o && hs_total == base + 2) seen = 1'b1;
        end
        if (!seen) fail_now("stall_arm_timeout");
        else begin
          dout_rdy_i = 1'b0;
          held = {dout_last_o, dout_o};
          check("stall_word", {15'b0, held}, {15'b0, 17'h0_0006});
          for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_hold", {15'b0, dout_last_o, dout_o}, {15'b0, held});
            check("stall_val", {31'b0, dout_val_o}, 32'h1);
            check("stall_din_rdy", {31'b0, din_rdy_o}, 32'h0);
          end
          @(posedge clk); #1;
          dout_rdy_i = 1'b1;
        end
      end
    join
    drain("stall");
    check("stall_word_count", hs_total - base, WPF);
    check("frame_cnt_stall", {16'b0, frame_cnt_o}, 32'd3);

    // input gaps mid-payload
    send_frame(16'h0009, 16'h000A, 16'h000B, 16'h000C, 2);
    din_val_i = 1'b0;
    drain("gaps");
    check("frame_cnt_gaps", {16'b0, frame_cnt_o}, 32'd4);

    // two back-to-back frames at full throughput
    base = hs_total;
    tp_first = -1;
    tp_arm = 1'b1;
    send_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444, 0);
    send_frame(16'h8000, 16'h8000, 16'h0001, 16'h0002, 0);
    din_val_i = 1'b0;
    drain("b2b");
    tp_arm = 1'b0;
    check("b2b_word_count", hs_total - base, 2 * WPF);
    check("b2b_span_cycles", last_hs_cyc - tp_first, 2 * WPF - 1);
    check("frame_cnt_b2b", {16'b0, frame_cnt_o}, 32'd6);

    // reset after the second word of a frame
    base = hs_total;
    exp_q.push_back({1'b0, 16'hA5A5});
    exp_q.push_back({1'b0, 16'h0010});
    put(16'h0010, 0);
    put(16'h0011, 0);
    din_val_i = 1'b0;
    check("pre_reset_words", hs_total - base, 2);
    arst_i = 1'b1;
    exp_q.delete();
    #1;
    check("mid_reset_val", {31'b0, dout_val_o}, 32'h0);
    check("mid_reset_dout", {16'b0, dout_o}, 32'h0);
    check("mid_reset_last", {31'b0, dout_last_o}, 32'h0);
    check("mid_reset_busy", {31'b0, busy_o}, 32'h0);
    check("mid_reset_frame_cnt", {16'b0, frame_cnt_o}, 32'h0);
    @(posedge clk); #1;
    arst_i = 1'b0;
    @(posedge clk); #1;
    send_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004, 0);
    din_val_i = 1'b0;
    drain("post_reset");
    check("frame_cnt_post_reset", {16'b0, frame_cnt_o}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
